// File: rtl/star_pkg.sv
// Shared constants, op/state encodings and the RAM address helper for the star bounding-box mapper.
package star_pkg;

  localparam int unsigned X_SZ    = 8;
  localparam int unsigned Y_SZ    = 7;
  localparam int unsigned ADDR_SZ = 15;
  localparam int unsigned COL_SZ  = 3;
  localparam int unsigned MAX_X   = 160;
  localparam int unsigned MAX_Y   = 120;

  localparam logic [COL_SZ-1:0] THRESHOLD = COL_SZ'(0);

  typedef enum logic [1:0] {
    OP_ROWS  = 2'd0,
    OP_LEFT  = 2'd1,
    OP_RIGHT = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // y*160 + x without a multiplier
  function automatic logic [ADDR_SZ-1:0] pix_addr(input logic [X_SZ-1:0] x,
                                                  input logic [Y_SZ-1:0] y);
    return (ADDR_SZ'(y) << 7) + (ADDR_SZ'(y) << 5) + ADDR_SZ'(x);
  endfunction

endpackage

// File: rtl/star_edge_walker.sv
// Probe engine: steps outward from a start pixel along +y, -x or +x until a dark pixel
// or the image edge, reporting the last lit coordinate along the walked axis.
module star_edge_walker
  import star_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  op_e                 i_dir,
  input  logic [X_SZ-1:0]     i_x,
  input  logic [Y_SZ-1:0]     i_y,
  input  logic [COL_SZ-1:0]   i_pix,
  output logic [ADDR_SZ-1:0]  o_rd_addr,
  output logic                o_busy,
  output logic                o_finish_c,
  output logic [X_SZ-1:0]     o_last_c
);

  state_e              r_state, w_next;
  op_e                 r_dir, w_dir;
  logic [X_SZ-1:0]     r_x, w_sx, w_nx, r_last, w_last;
  logic [Y_SZ-1:0]     r_y, w_sy, w_ny;
  logic [ADDR_SZ-1:0]  r_rd_addr;
  logic                r_busy, w_oob, w_load, w_finish, w_idle;

  assign w_idle = (r_state == ST_IDLE);
  assign w_dir  = w_idle ? i_dir : r_dir;
  assign w_sx   = w_idle ? i_x   : r_x;
  assign w_sy   = w_idle ? i_y   : r_y;

  // Next probe coordinate and whether it would leave the image
  always_comb begin
    w_nx  = w_sx;
    w_ny  = w_sy;
    w_oob = 1'b0;
    case (w_dir)
      OP_ROWS: begin
        w_ny  = w_sy + Y_SZ'(1);
        w_oob = (w_sy >= Y_SZ'(MAX_Y - 1));
      end
      OP_LEFT: begin
        w_nx  = w_sx - X_SZ'(1);
        w_oob = (w_sx == '0);
      end
      default: begin
        w_nx  = w_sx + X_SZ'(1);
        w_oob = (w_sx >= X_SZ'(MAX_X - 1));
      end
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_finish = 1'b0;
    w_last   = r_last;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_last = (i_dir == OP_ROWS) ? X_SZ'(i_y) : i_x;
          if (w_oob) begin
            w_next   = ST_DONE;
            w_finish = 1'b1;
          end else begin
            w_next = ST_ISSUE;
            w_load = 1'b1;
          end
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_EVAL;
      ST_EVAL: begin
        if (i_pix > THRESHOLD) begin
          w_last = (r_dir == OP_ROWS) ? X_SZ'(r_y) : r_x;
          if (w_oob) begin
            w_next   = ST_DONE;
            w_finish = 1'b1;
          end else begin
            w_next = ST_ISSUE;
            w_load = 1'b1;
          end
        end else begin
          w_next   = ST_DONE;
          w_finish = 1'b1;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dir     <= OP_ROWS;
      r_x       <= '0;
      r_y       <= '0;
      r_last    <= '0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_last  <= w_last;
      if (w_idle && i_start) r_dir <= i_dir;
      if (w_load) begin
        r_x       <= w_nx;
        r_y       <= w_ny;
        r_rd_addr <= pix_addr(w_nx, w_ny);
      end
    end
  end

  assign o_rd_addr  = r_rd_addr;
  assign o_busy     = r_busy;
  assign o_finish_c = w_finish;
  assign o_last_c   = w_last;

endmodule

// File: rtl/star_bbox_mapper.sv
// Answers the star-scan master's map commands: walks the image RAM from the seed pixel and
// reports the star's bounding box with a one-cycle found pulse per command.
module star_bbox_mapper
  import star_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                goMapRows,
  input  logic                goMapColumnsL,
  input  logic                goMapColumnsR,
  input  logic [X_SZ-1:0]     seedX,
  input  logic [Y_SZ-1:0]     seedY,
  input  logic [COL_SZ-1:0]   pixVal,
  output logic [ADDR_SZ-1:0]  rdAddr,
  output logic                busy,
  output logic                topBottomFound,
  output logic                leftFound,
  output logic                rightFound,
  output logic [Y_SZ-1:0]     yTop,
  output logic [Y_SZ-1:0]     yBottom,
  output logic [X_SZ-1:0]     xLeft,
  output logic [X_SZ-1:0]     xRight
);

  logic [X_SZ-1:0]  r_sx, r_x_left, r_x_right, w_start_x, w_last_c;
  logic [Y_SZ-1:0]  r_sy, r_y_top, r_y_bottom, w_start_y, w_ym, w_cur_sy;
  logic [Y_SZ:0]    w_ym_sum;
  logic             r_tb_found, r_l_found, r_r_found;
  logic             w_busy, w_idle, w_start, w_finish_c;
  op_e              r_op, w_op, w_cur_op;

  assign w_idle  = ~w_busy;
  assign w_start = w_idle & (goMapRows | goMapColumnsL | goMapColumnsR);
  assign w_op    = goMapRows ? OP_ROWS : (goMapColumnsL ? OP_LEFT : OP_RIGHT);

  // Column ops walk the middle row of the current vertical extent
  assign w_ym_sum  = {1'b0, r_y_top} + {1'b0, r_y_bottom};
  assign w_ym      = Y_SZ'(w_ym_sum >> 1);
  assign w_start_x = goMapRows ? seedX : r_sx;
  assign w_start_y = goMapRows ? seedY : w_ym;

  // A zero-probe op finishes in the accept cycle, before r_op/r_sy are loaded
  assign w_cur_op = w_idle ? w_op  : r_op;
  assign w_cur_sy = w_idle ? seedY : r_sy;

  star_edge_walker u_walker (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_dir      (w_op),
    .i_x        (w_start_x),
    .i_y        (w_start_y),
    .i_pix      (pixVal),
    .o_rd_addr  (rdAddr),
    .o_busy     (w_busy),
    .o_finish_c (w_finish_c),
    .o_last_c   (w_last_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= OP_ROWS;
      r_sx       <= '0;
      r_sy       <= '0;
      r_y_top    <= '0;
      r_y_bottom <= '0;
      r_x_left   <= '0;
      r_x_right  <= '0;
      r_tb_found <= 1'b0;
      r_l_found  <= 1'b0;
      r_r_found  <= 1'b0;
    end else begin
      r_tb_found <= w_finish_c && (w_cur_op == OP_ROWS);
      r_l_found  <= w_finish_c && (w_cur_op == OP_LEFT);
      r_r_found  <= w_finish_c && (w_cur_op == OP_RIGHT);
      if (w_start) begin
        r_op <= w_op;
        if (goMapRows) begin
          r_sx <= seedX;
          r_sy <= seedY;
        end
      end
      if (w_finish_c) begin
        case (w_cur_op)
          OP_ROWS: begin
            r_y_top    <= w_cur_sy;
            r_y_bottom <= w_last_c[Y_SZ-1:0];
          end
          OP_LEFT:  r_x_left  <= w_last_c;
          default:  r_x_right <= w_last_c;
        endcase
      end
    end
  end

  assign busy           = w_busy;
  assign topBottomFound = r_tb_found;
  assign leftFound      = r_l_found;
  assign rightFound     = r_r_found;
  assign yTop           = r_y_top;
  assign yBottom        = r_y_bottom;
  assign xLeft          = r_x_left;
  assign xRight         = r_x_right;

endmodule

// File: tb/tb_star_bbox_mapper.sv
// Directed bench for star_bbox_mapper: image scenes in a behavioural RAM, table of commands
// with hand-computed latency and bounds, plus reset-abort and address corner sequences.
module tb_star_bbox_mapper;

  localparam int NPIX = 19200;

  logic        clk = 1'b0;
  logic        reset;
  logic        goMapRows, goMapColumnsL, goMapColumnsR;
  logic [7:0]  seedX;
  logic [6:0]  seedY;
  logic [2:0]  pixVal;
  logic [14:0] rdAddr;
  logic        busy, topBottomFound, leftFound, rightFound;
  logic [6:0]  yTop, yBottom;
  logic [7:0]  xLeft, xRight;

  logic [2:0]  mem [0:NPIX-1];
  int          n_pass = 0;
  int          n_total = 0;
  bit          seen_max_addr = 0;
  bit          bad_addr = 0;

  star_bbox_mapper dut (
    .clk(clk), .reset(reset),
    .goMapRows(goMapRows), .goMapColumnsL(goMapColumnsL), .goMapColumnsR(goMapColumnsR),
    .seedX(seedX), .seedY(seedY), .pixVal(pixVal), .rdAddr(rdAddr), .busy(busy),
    .topBottomFound(topBottomFound), .leftFound(leftFound), .rightFound(rightFound),
    .yTop(yTop), .yBottom(yBottom), .xLeft(xLeft), .xRight(xRight)
  );

  always #5 clk = ~clk;

  // Registered RAM output, one cycle after the address
  always @(posedge clk) pixVal <= (int'(rdAddr) < NPIX) ? mem[rdAddr] : 3'd0;

  always @(negedge clk) begin
    if (busy && int'(rdAddr) >= NPIX) bad_addr = 1;
    if (busy && rdAddr == 15'd19199) seen_max_addr = 1;
  end

  typedef struct {
    int         scene;
    logic [2:0] cmd;     // {rows, left, right}
    int         sx, sy;
    bit         mid_l;
    int         cyc;
    logic [2:0] mask;    // {topBottomFound, leftFound, rightFound}
    int         yt, yb, xl, xr;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic put(input int x, input int y, input logic [2:0] v);
    mem[y*160 + x] = v;
  endtask

  task automatic load_scene(input int s);
    for (int i = 0; i < NPIX; i++) mem[i] = 3'd0;
    case (s)
      1, 4: begin
        put(10, 20, 3'd5); put(10, 21, 3'd6); put(10, 22, 3'd7); put(10, 23, 3'd1);
        for (int x = 7; x <= 14; x++) put(x, 21, 3'd3);
        if (s == 4) for (int x = 1; x <= 3; x++) put(x, 0, 3'd2);
      end
      2: put(0, 119, 3'd7);
      3: for (int x = 0; x < 160; x++) put(x, 119, 3'd4);
      default: ;
    endcase
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int first, width, busy1, busy_f, busy_after;
    logic [2:0] mask, f;
    bit done;
    if (v.scene != 0) load_scene(v.scene);
    @(negedge clk);
    seedX = 8'(v.sx); seedY = 7'(v.sy);
    {goMapRows, goMapColumnsL, goMapColumnsR} = v.cmd;
    first = -1; width = 0; mask = 3'b000; busy1 = 0; busy_f = 0; busy_after = 1; done = 0;
    for (int c = 1; c <= 1000 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busy1 = int'(busy);
        {goMapRows, goMapColumnsL, goMapColumnsR} = 3'b000;
      end
      if (v.mid_l && c == 5) goMapColumnsL = 1'b1;
      if (c == 6) goMapColumnsL = 1'b0;
      f = {topBottomFound, leftFound, rightFound};
      if (f != 3'b000) begin
        width++;
        mask |= f;
        if (first < 0) begin
          first  = c;
          busy_f = int'(busy);
        end
      end
      if (first >= 0 && c == first + 1) busy_after = int'(busy);
      if (first >= 0 && c >= first + 2) done = 1;
    end
    check({tag, " found_cycle"}, first, v.cyc);
    check({tag, " found_mask"}, int'(mask), int'(v.mask));
    check({tag, " found_width"}, width, 1);
    check({tag, " busy_cycle1"}, busy1, 1);
    check({tag, " busy_at_found"}, busy_f, 1);
    check({tag, " busy_after"}, busy_after, 0);
    check({tag, " yTop"}, int'(yTop), v.yt);
    check({tag, " yBottom"}, int'(yBottom), v.yb);
    check({tag, " xLeft"}, int'(xLeft), v.xl);
    check({tag, " xRight"}, int'(xRight), v.xr);
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    int nf;
    reset = 1'b1;
    goMapRows = 1'b0; goMapColumnsL = 1'b0; goMapColumnsR = 1'b0;
    seedX = '0; seedY = '0;
    load_scene(0);

    //         scene cmd     sx  sy  midL cyc  mask    yt   yb   xl  xr
    vecs[0] = '{1, 3'b100, 10, 20, 0,  13, 3'b100,  20,  23,  0,   0};
    vecs[1] = '{0, 3'b010,  0,  0, 0,  13, 3'b010,  20,  23,  7,   0};
    vecs[2] = '{0, 3'b001,  0,  0, 0,  16, 3'b001,  20,  23,  7,  14};
    vecs[3] = '{2, 3'b100,  0, 119, 0,  1, 3'b100, 119, 119,  7,  14};
    vecs[4] = '{0, 3'b010,  0,  0, 0,   1, 3'b010, 119, 119,  0,  14};
    vecs[5] = '{0, 3'b001,  0,  0, 0,   4, 3'b001, 119, 119,  0,   0};
    vecs[6] = '{3, 3'b001,  0,  0, 0, 478, 3'b001, 119, 119,  0, 159};
    vecs[7] = '{1, 3'b101, 10, 20, 1,  13, 3'b100,  20,  23,  0, 159};
    vecs[8] = '{0, 3'b011,  0,  0, 0,  13, 3'b010,  20,  23,  7, 159};

    #1;
    check("reset busy", int'(busy), 0);
    check("reset rdAddr", int'(rdAddr), 0);
    check("reset bounds", int'({yTop, yBottom, xLeft, xRight}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      // Last rows probe was (10,24): 24*160+10
      if (i == 0) check("rdAddr_hold", int'(rdAddr), 3850);
      if (i == 6) begin
        check("rdAddr_19199_seen", int'(seen_max_addr), 1);
        check("rdAddr_in_range", int'(bad_addr), 0);
      end
    end

    // Reset in the WAIT cycle of the first rows probe aborts everything
    load_scene(1);
    @(negedge clk);
    seedX = 8'd10; seedY = 7'd20; goMapRows = 1'b1;
    @(negedge clk);
    goMapRows = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort yTop", int'(yTop), 0);
    check("abort yBottom", int'(yBottom), 0);
    check("abort xLeft", int'(xLeft), 0);
    check("abort xRight", int'(xRight), 0);
    check("abort rdAddr", int'(rdAddr), 0);
    @(negedge clk);
    reset = 1'b0;
    nf = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (topBottomFound | leftFound | rightFound | busy) nf++;
    end
    check("abort no_found_or_busy", nf, 0);

    // Column op before any rows op walks row 0 from x=0
    v = '{4, 3'b001, 0, 0, 0, 13, 3'b001, 0, 0, 0, 3};
    run_vec(v, "post_reset_R");
    v = '{0, 3'b100, 10, 20, 0, 13, 3'b100, 20, 23, 0, 3};
    run_vec(v, "post_reset_rows");
    check("final rdAddr_in_range", int'(bad_addr), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
